// File: rtl/bbs_pkg.sv
// bbs_pkg: shared BBS constants and arbiter FSM encoding
package bbs_pkg;
  localparam int BBS_SIZE = 16;
  localparam int BBS_MOD = 40633;
  localparam int BBS_SEED = 884;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker, first set request at or after ptr (wrapping)
module rr_pick #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic [NREQ-1:0]         onehot,
  output logic [$clog2(NREQ)-1:0] idx
);
  localparam int IW = $clog2(NREQ);
  // Scan from the far end down so the nearest requester to ptr is written last and wins.
  always_comb begin
    onehot = '0;
    idx = '0;
    for (int i = NREQ - 1; i >= 0; i--)
      if (req[IW'((int'(ptr) + i) % NREQ)]) begin
        idx = IW'((int'(ptr) + i) % NREQ);
        onehot = NREQ'(1) << idx;
      end
  end
endmodule

// File: rtl/bbs_word_arbiter.sv
// bbs_word_arbiter: round-robin arbiter sharing one Blum-Blum-Shub bit source,
// sequencing an external 1-cycle squarer and delivering WORD-bit words per grant.
module bbs_word_arbiter
  import bbs_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int WORD = 16,
  parameter int SIZE = BBS_SIZE,
  parameter int MOD  = BBS_MOD,
  parameter int SEED = BBS_SEED
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req,
  input  logic                    reseed,
  input  logic [SIZE-1:0]         seed_in,
  output logic [SIZE-1:0]         mul_x,
  input  logic [SIZE-1:0]         mul_out,
  output logic [NREQ-1:0]         gnt,
  output logic                    out_valid,
  output logic [WORD-1:0]         out_word,
  output logic [$clog2(NREQ)-1:0] out_id,
  output logic                    seed_err
);
  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(2 * WORD) + 1;
  localparam logic [CW-1:0] LAST = CW'(2 * WORD - 1);
  localparam logic [SIZE-1:0] L_MOD = SIZE'(MOD);
  localparam logic [SIZE-1:0] L_SEED = SIZE'(SEED);

  state_t          r_state;
  logic [SIZE-1:0] r_seed;
  logic [SIZE-1:0] r_pend;
  logic            r_pend_v;
  logic [IW-1:0]   r_ptr;
  logic [IW-1:0]   r_id;
  logic [CW-1:0]   r_bcnt;
  logic [WORD-1:0] r_word;
  logic [NREQ-1:0] r_gnt;
  logic            r_seed_err;
  logic [NREQ-1:0] w_onehot;
  logic [IW-1:0]   w_idx;
  logic            w_seed_ok;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req   (req),
    .ptr   (r_ptr),
    .onehot(w_onehot),
    .idx   (w_idx)
  );

  assign w_seed_ok = seed_in != '0 && seed_in < L_MOD;
  assign mul_x = r_seed;
  assign gnt = r_gnt;
  assign out_valid = r_state == DONE;
  assign out_word = r_word;
  assign out_id = r_id;
  assign seed_err = r_seed_err;

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_state <= IDLE;
      r_seed <= L_SEED;
      r_pend <= '0;
      r_pend_v <= 1'b0;
      r_ptr <= '0;
      r_id <= '0;
      r_bcnt <= '0;
      r_word <= '0;
      r_gnt <= '0;
      r_seed_err <= 1'b0;
    end else begin
      r_seed_err <= reseed && !w_seed_ok;
      case (r_state)
        IDLE: begin
          if (reseed && w_seed_ok) r_seed <= seed_in;
          if (|req) begin
            r_gnt <= w_onehot;
            r_id <= w_idx;
            r_bcnt <= '0;
            r_word <= '0;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_bcnt <= r_bcnt + CW'(1);
          // The seed is busy feeding the squarer, so a reseed waits until the word is out.
          if (reseed && w_seed_ok) begin
            r_pend <= seed_in;
            r_pend_v <= 1'b1;
          end
          if (r_bcnt[0]) begin
            r_seed <= mul_out == r_seed ? L_SEED : mul_out;
            r_word <= WORD'({r_word, mul_out[0]});
          end
          if (r_bcnt == LAST) r_state <= DONE;
        end
        DONE: begin
          r_gnt <= '0;
          r_ptr <= r_id == IW'(NREQ - 1) ? '0 : r_id + IW'(1);
          r_pend_v <= 1'b0;
          r_state <= IDLE;
          if (reseed && w_seed_ok) r_seed <= seed_in;
          else if (r_pend_v) r_seed <= r_pend;
        end
        default: r_state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_bbs_word_arbiter.sv
// tb_bbs_word_arbiter: directed scenario bench for bbs_word_arbiter with a behavioural squarer
module tb_bbs_word_arbiter;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  req = '0;
  logic        reseed = 1'b0;
  logic [15:0] seed_in = '0;
  logic [15:0] mul_x;
  logic [15:0] mul_out = '0;
  logic [3:0]  gnt;
  logic        out_valid;
  logic [15:0] out_word;
  logic [1:0]  out_id;
  logic        seed_err;
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  always @(posedge clk) mul_out <= 16'((32'(mul_x) * 32'(mul_x)) % 32'd40633);

  bbs_word_arbiter #(.NREQ(4), .WORD(16)) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .reseed   (reseed),
    .seed_in  (seed_in),
    .mul_x    (mul_x),
    .mul_out  (mul_out),
    .gnt      (gnt),
    .out_valid(out_valid),
    .out_word (out_word),
    .out_id   (out_id),
    .seed_err (seed_err)
  );

  task automatic gold(input logic [15:0] s0, output logic [15:0] w, output logic [15:0] s1);
    logic [15:0] s, n;
    s = s0;
    w = '0;
    for (int i = 0; i < 16; i++) begin
      n = 16'((32'(s) * 32'(s)) % 32'd40633);
      w = {w[14:0], n[0]};
      s = (n == s) ? 16'd884 : n;
    end
    s1 = s;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!out_valid && n < 100);
    tests++;
    if (!out_valid) begin
      fails++;
      $display("FAIL valid_timeout: no out_valid after %0d cycles", n);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req = '0;
    reseed = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tests++; if (gnt !== 4'b0) begin fails++; $display("FAIL rst_gnt: got %b want 0000", gnt); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_valid: got %b want 0", out_valid); end
    tests++; if (out_word !== 16'd0) begin fails++; $display("FAIL rst_word: got %0d want 0", out_word); end
    tests++; if (out_id !== 2'd0) begin fails++; $display("FAIL rst_id: got %0d want 0", out_id); end
    tests++; if (seed_err !== 1'b0) begin fails++; $display("FAIL rst_seed_err: got %b want 0", seed_err); end
    tests++; if (mul_x !== 16'd884) begin fails++; $display("FAIL rst_seed: got %0d want 884", mul_x); end
  endtask

  task automatic test_single();
    logic [15:0] w, s1;
    int n;
    gold(16'd884, w, s1);
    do_reset();
    req = 4'b0001;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
      if (n == 1) begin
        tests++; if (gnt !== 4'b0001) begin fails++; $display("FAIL s1_gnt: got %b want 0001", gnt); end
      end
      if (n == 3) begin
        tests++; if (mul_x !== 16'd9429) begin fails++; $display("FAIL s1_seed1: got %0d want 9429", mul_x); end
      end
      if (n == 5) begin
        tests++; if (mul_x !== 16'd1037) begin fails++; $display("FAIL s1_seed2: got %0d want 1037", mul_x); end
      end
    end while (!out_valid && n < 100);
    tests++; if (n !== 33) begin fails++; $display("FAIL s1_latency: got %0d want 33", n); end
    tests++; if (out_id !== 2'd0) begin fails++; $display("FAIL s1_id: got %0d want 0", out_id); end
    tests++; if (out_word[15:14] !== 2'b11) begin fails++; $display("FAIL s1_msbs: got %b want 11", out_word[15:14]); end
    tests++; if (out_word !== w) begin fails++; $display("FAIL s1_word: got %h want %h", out_word, w); end
    tests++; if (mul_x !== s1) begin fails++; $display("FAIL s1_end_seed: got %0d want %0d", mul_x, s1); end
    req = '0;
    @(posedge clk);
    #1;
    tests++; if (gnt !== 4'b0) begin fails++; $display("FAIL s1_gnt_drop: got %b want 0000", gnt); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL s1_valid_pulse: got %b want 0", out_valid); end
  endtask

  task automatic test_round_robin();
    logic [15:0] s, w;
    int n;
    s = 16'd884;
    do_reset();
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      gold(s, w, s);
      wait_valid(n);
      tests++; if (out_id !== 2'(k % 4)) begin fails++; $display("FAIL rr_id%0d: got %0d want %0d", k, out_id, k % 4); end
      tests++; if (gnt !== 4'(1 << (k % 4))) begin fails++; $display("FAIL rr_gnt%0d: got %b want %b", k, gnt, 4'(1 << (k % 4))); end
      tests++; if (n !== (k == 0 ? 33 : 34)) begin fails++; $display("FAIL rr_spacing%0d: got %0d want %0d", k, n, k == 0 ? 33 : 34); end
      tests++; if (out_word !== w) begin fails++; $display("FAIL rr_word%0d: got %h want %h", k, out_word, w); end
    end
    req = '0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_priority();
    int n;
    do_reset();
    req = 4'b0001;
    wait_valid(n);
    req = 4'b0101;
    wait_valid(n);
    tests++; if (out_id !== 2'd2) begin fails++; $display("FAIL pri_first: got %0d want 2", out_id); end
    tests++; if (n !== 34) begin fails++; $display("FAIL pri_spacing: got %0d want 34", n); end
    wait_valid(n);
    tests++; if (out_id !== 2'd0) begin fails++; $display("FAIL pri_second: got %0d want 0", out_id); end
    req = '0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reseed();
    logic [15:0] w, s1;
    int n;
    gold(16'd884, w, s1);
    do_reset();
    reseed = 1'b1;
    seed_in = 16'd0;
    @(posedge clk);
    #1;
    reseed = 1'b0;
    tests++; if (seed_err !== 1'b1) begin fails++; $display("FAIL rs_err_zero: got %b want 1", seed_err); end
    tests++; if (mul_x !== 16'd884) begin fails++; $display("FAIL rs_keep_zero: got %0d want 884", mul_x); end
    @(posedge clk);
    #1;
    tests++; if (seed_err !== 1'b0) begin fails++; $display("FAIL rs_err_pulse: got %b want 0", seed_err); end
    reseed = 1'b1;
    seed_in = 16'd40633;
    @(posedge clk);
    #1;
    reseed = 1'b0;
    tests++; if (seed_err !== 1'b1) begin fails++; $display("FAIL rs_err_mod: got %b want 1", seed_err); end
    tests++; if (mul_x !== 16'd884) begin fails++; $display("FAIL rs_keep_mod: got %0d want 884", mul_x); end
    req = 4'b0001;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
      if (n == 5) begin
        reseed = 1'b1;
        seed_in = 16'd3;
      end
      if (n == 6) begin
        reseed = 1'b0;
        tests++; if (seed_err !== 1'b0) begin fails++; $display("FAIL rs_run_err: got %b want 0", seed_err); end
        tests++; if (mul_x === 16'd3) begin fails++; $display("FAIL rs_run_early: got %0d want old sequence", mul_x); end
      end
    end while (!out_valid && n < 100);
    tests++; if (out_word !== w) begin fails++; $display("FAIL rs_run_word: got %h want %h", out_word, w); end
    tests++; if (mul_x !== s1) begin fails++; $display("FAIL rs_done_seed: got %0d want %0d", mul_x, s1); end
    req = '0;
    @(posedge clk);
    #1;
    tests++; if (mul_x !== 16'd3) begin fails++; $display("FAIL rs_applied: got %0d want 3", mul_x); end
  endtask

  task automatic test_fixed_point();
    logic [15:0] w1, w884, s1;
    int n;
    gold(16'd1, w1, s1);
    gold(16'd884, w884, s1);
    do_reset();
    reseed = 1'b1;
    seed_in = 16'd1;
    @(posedge clk);
    #1;
    reseed = 1'b0;
    tests++; if (mul_x !== 16'd1) begin fails++; $display("FAIL fp_load: got %0d want 1", mul_x); end
    req = 4'b0001;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
      if (n == 3) begin
        tests++; if (mul_x !== 16'd884) begin fails++; $display("FAIL fp_reload: got %0d want 884", mul_x); end
      end
    end while (!out_valid && n < 100);
    tests++; if (out_word !== w1) begin fails++; $display("FAIL fp_word: got %h want %h", out_word, w1); end
    tests++; if (out_word !== {1'b1, w884[15:1]}) begin fails++; $display("FAIL fp_shift: got %h want %h", out_word, {1'b1, w884[15:1]}); end
    req = '0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid_run();
    logic [15:0] w, s1;
    int n;
    gold(16'd884, w, s1);
    do_reset();
    req = 4'b0001;
    repeat (11) @(posedge clk);
    #1;
    tests++; if (gnt !== 4'b0001) begin fails++; $display("FAIL mr_gnt_run: got %b want 0001", gnt); end
    reset = 1'b1;
    req = '0;
    #1;
    tests++; if (gnt !== 4'b0) begin fails++; $display("FAIL mr_gnt: got %b want 0000", gnt); end
    tests++; if (mul_x !== 16'd884) begin fails++; $display("FAIL mr_seed: got %0d want 884", mul_x); end
    tests++; if (out_word !== 16'd0) begin fails++; $display("FAIL mr_word: got %h want 0000", out_word); end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL mr_no_valid: got %b want 0", out_valid); end
    end
    reset = 1'b0;
    req = 4'b0001;
    wait_valid(n);
    tests++; if (n !== 33) begin fails++; $display("FAIL mr_latency: got %0d want 33", n); end
    tests++; if (out_id !== 2'd0) begin fails++; $display("FAIL mr_id: got %0d want 0", out_id); end
    tests++; if (out_word !== w) begin fails++; $display("FAIL mr_word_again: got %h want %h", out_word, w); end
    req = '0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_priority();
    test_reseed();
    test_fixed_point();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
